// File: rtl/mic_array_dir_detect.sv
// mic_array_dir_detect
//   I2S microphone-array front end with a per-pair loudness direction detector.
//   All timing runs in the clk domain. mic_clk and mic_ws are registered outputs.
//   Internal clock enables (rise_en / fall_en) mark the mic_clk edges, so no
//   logic is clocked by a derived clock.
//
// Ports
//   clk        in   system clock
//   rst        in   asynchronous reset, active-high
//   mic_clk    out  I2S bit clock, period 2*CLK_DIV clk cycles
//   mic_ws     out  I2S word select (0 = left slot, 1 = right slot)
//   mic_da     in   [NUM_PAIRS] serial data, bit p from pair p
//   led        out  [2*NUM_PAIRS] code per pair at [2p+1:2p]:
//                   10 = left louder, 01 = right louder, 11 = undecided
//   frame_vld  out  one-clk pulse when a full L/R frame has been latched
//   win_vld    out  one-clk pulse when led has just been updated
//
// Output events: frame_vld and win_vld are single-cycle strobes with no ready.
// A strobe is valid only in the cycle it is high. The consumer must sample it
// then, because nothing is held or retried.

module mic_array_dir_detect #(
  parameter int CLK_DIV       = 512,
  parameter int BITS_PER_SLOT = 32,
  parameter int SAMPLE_W      = 24,
  parameter int NUM_PAIRS     = 1,
  parameter int SHIFT         = 10,
  parameter int WIN_LOG2      = 2,
  parameter int MIC_GAP       = 100
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   mic_clk,
  output logic                   mic_ws,
  input  logic [NUM_PAIRS-1:0]   mic_da,
  output logic [2*NUM_PAIRS-1:0] led,
  output logic                   frame_vld,
  output logic                   win_vld
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W  = $clog2(BITS_PER_SLOT);
  localparam int AMP_W  = SAMPLE_W - SHIFT;
  localparam int ACC_W  = AMP_W + WIN_LOG2;
  localparam int CMP_W  = ACC_W + 1;
  localparam int FC_W   = (WIN_LOG2 > 0) ? WIN_LOG2 : 1;
  localparam int FRAMES = 1 << WIN_LOG2;

  // Bit clock divider
  logic [DIV_W-1:0] div_cnt;
  logic             div_wrap;
  logic             rise_en;
  logic             fall_en;

  assign div_wrap = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign rise_en  = div_wrap & ~mic_clk;
  assign fall_en  = div_wrap &  mic_clk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      mic_clk <= 1'b0;
    end else if (div_wrap) begin
      div_cnt <= '0;
      mic_clk <= ~mic_clk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Slot bit index. Word select changes only on a falling bit-clock edge.
  logic [BIT_W-1:0] bit_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_idx <= '0;
      mic_ws  <= 1'b0;
    end else if (fall_en) begin
      if (bit_idx == BIT_W'(BITS_PER_SLOT - 1)) begin
        bit_idx <= '0;
        mic_ws  <= ~mic_ws;
      end else begin
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

  // I2S has a one-bit delay. The MSB arrives at bit_idx 1 and the LSB at
  // bit_idx SAMPLE_W. Bit 0 and the trailing bits are not part of the sample.
  logic cap_bit;
  logic cap_last;
  logic cap_done;

  assign cap_bit  = rise_en && (bit_idx >= BIT_W'(1)) && (bit_idx <= BIT_W'(SAMPLE_W));
  assign cap_last = rise_en && mic_ws && (bit_idx == BIT_W'(SAMPLE_W));

  // Window bookkeeping, shared by all pairs
  logic [FC_W-1:0] frame_cnt;
  logic            win_last;
  logic            sum_vld;

  assign win_last = (frame_cnt == FC_W'(FRAMES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_done  <= 1'b0;
      frame_vld <= 1'b0;
      frame_cnt <= '0;
      sum_vld   <= 1'b0;
      win_vld   <= 1'b0;
    end else begin
      cap_done  <= cap_last;
      frame_vld <= cap_done;
      sum_vld   <= frame_vld && win_last;
      win_vld   <= sum_vld;
      if (frame_vld) begin
        frame_cnt <= win_last ? '0 : frame_cnt + 1'b1;
      end
    end
  end

  // Per-pair capture, amplitude, accumulation and decision
  for (genvar p = 0; p < NUM_PAIRS; p++) begin : g_pair
    logic [SAMPLE_W-1:0] sr_l, sr_r, samp_l, samp_r;
    logic [AMP_W-1:0]    amp_l, amp_r;
    logic [ACC_W-1:0]    acc_l, acc_r, sum_l, sum_r;
    logic [CMP_W-1:0]    wide_l, wide_r, gap;
    logic [1:0]          code;

    // Arithmetic shift keeps the top AMP_W bits. The most negative value
    // negates to 2^(AMP_W-1), which still fits in AMP_W unsigned bits.
    assign amp_l = samp_l[SAMPLE_W-1] ? AMP_W'(~samp_l[SAMPLE_W-1:SHIFT] + AMP_W'(1))
                                      : samp_l[SAMPLE_W-1:SHIFT];
    assign amp_r = samp_r[SAMPLE_W-1] ? AMP_W'(~samp_r[SAMPLE_W-1:SHIFT] + AMP_W'(1))
                                      : samp_r[SAMPLE_W-1:SHIFT];

    assign wide_l = CMP_W'(sum_l);
    assign wide_r = CMP_W'(sum_r);
    assign gap    = CMP_W'(MIC_GAP);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sr_l   <= '0;
        sr_r   <= '0;
        samp_l <= '0;
        samp_r <= '0;
        acc_l  <= '0;
        acc_r  <= '0;
        sum_l  <= '0;
        sum_r  <= '0;
        code   <= 2'b11;
      end else begin
        if (cap_bit) begin
          if (mic_ws) sr_r <= {sr_r[SAMPLE_W-2:0], mic_da[p]};
          else        sr_l <= {sr_l[SAMPLE_W-2:0], mic_da[p]};
        end
        if (cap_done) begin
          samp_l <= sr_l;
          samp_r <= sr_r;
        end
        // The closing frame goes straight into the sum. The accumulator then
        // restarts at 0, so every frame lands in exactly one window.
        if (frame_vld) begin
          if (win_last) begin
            sum_l <= acc_l + ACC_W'(amp_l);
            sum_r <= acc_r + ACC_W'(amp_r);
            acc_l <= '0;
            acc_r <= '0;
          end else begin
            acc_l <= acc_l + ACC_W'(amp_l);
            acc_r <= acc_r + ACC_W'(amp_r);
          end
        end
        if (sum_vld) begin
          if (wide_l > wide_r + gap)      code <= 2'b10;
          else if (wide_r > wide_l + gap) code <= 2'b01;
          else                            code <= 2'b11;
        end
      end
    end

    assign led[2*p+1:2*p] = code;
  end

endmodule

// File: tb/tb_mic_array_dir_detect.sv
// Bench for mic_array_dir_detect with two pairs and a small clock divider.
// A mic model serialises per-frame sample values onto mic_da following I2S.
// A behavioural model sums per-window amplitudes and derives the expected led code.

module tb_mic_array_dir_detect;
  localparam int NP = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mic_clk, mic_ws;
  logic [NP-1:0] mic_da;
  logic [2*NP-1:0] led;
  logic          frame_vld, win_vld;

  int total = 0;
  int bad   = 0;

  logic [23:0] cur_l [NP];
  logic [23:0] cur_r [NP];
  logic [23:0] snap_l [NP];
  logic [23:0] snap_r [NP];

  int          acc_l [NP];
  int          acc_r [NP];
  int          fcnt;
  logic [3:0]  exp_led;
  logic [3:0]  exp_q [$];

  always #5 clk = ~clk;

  mic_array_dir_detect #(
    .CLK_DIV(2), .BITS_PER_SLOT(32), .SAMPLE_W(24), .NUM_PAIRS(NP),
    .SHIFT(8), .WIN_LOG2(2), .MIC_GAP(100)
  ) dut (
    .clk(clk), .rst(rst), .mic_clk(mic_clk), .mic_ws(mic_ws),
    .mic_da(mic_da), .led(led), .frame_vld(frame_vld), .win_vld(win_vld)
  );

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Mic model. It drives each bit just after a mic_clk fall. A slot starts at
  // the fall where ws changes, or at reset release. Position 0 is the I2S
  // delay bit, positions 1..24 carry the sample MSB first. Position 25 is
  // forced to 1 and the rest is random filler.
  initial begin : mic_driver
    int pos;
    logic prev_ws;
    bit in_rst;
    logic [23:0] w;
    pos = 0; prev_ws = 1'b0; in_rst = 1'b1; mic_da = '0;
    forever begin
      @(negedge mic_clk or rst);
      if (rst) begin
        pos = 0; prev_ws = 1'b0; in_rst = 1'b1; mic_da = '0;
      end else if (in_rst) begin
        in_rst = 1'b0;
        snap_l = cur_l;
        snap_r = cur_r;
      end else begin
        if (mic_ws !== prev_ws) pos = 0;
        else pos++;
        prev_ws = mic_ws;
        if (pos == 0 && mic_ws == 1'b0) begin
          snap_l = cur_l;
          snap_r = cur_r;
        end
        for (int p = 0; p < NP; p++) begin
          w = mic_ws ? snap_r[p] : snap_l[p];
          if (pos >= 1 && pos <= 24) mic_da[p] = w[24-pos];
          else if (pos == 25)        mic_da[p] = 1'b1;
          else                       mic_da[p] = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int amp(input logic [23:0] v);
    int s;
    s = $signed(v);
    s = s >>> 8;
    return (s < 0) ? -s : s;
  endfunction

  function automatic logic [1:0] decide(input int al, input int ar);
    if (al > ar + 100) return 2'b10;
    if (ar > al + 100) return 2'b01;
    return 2'b11;
  endfunction

  function automatic logic [23:0] rnd_val();
    int k;
    int t;
    k = $urandom_range(0, 3);
    t = $urandom_range(0, 'h20000);
    case (k)
      0:       return 24'($urandom);
      1:       return 24'(t);
      2:       return 24'(-t);
      default: return 24'(0);
    endcase
  endfunction

  task automatic set_cur(input logic [23:0] l0, input logic [23:0] r0,
                         input logic [23:0] l1, input logic [23:0] r1);
    cur_l[0] = l0; cur_r[0] = r0; cur_l[1] = l1; cur_r[1] = r1;
  endtask

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      acc_l[p] = 0;
      acc_r[p] = 0;
    end
    fcnt = 0;
    exp_led = 4'hF;
    exp_q.delete();
  endtask

  // Wait for one frame_vld and fold the frame into the model. On the
  // window's last frame, check the win_vld timing and the new led code.
  task automatic wait_frame();
    bit got;
    logic [3:0] e;
    got = 1'b0;
    for (int i = 0; i < 600 && !got; i++) begin
      @(negedge clk);
      if (frame_vld === 1'b1) got = 1'b1;
    end
    chk("frame_seen", 32'(got), 32'd1);
    if (!got) return;
    chk("led_hold", 32'(led), 32'(exp_led));
    chk("win_idle", 32'(win_vld), 32'd0);
    for (int p = 0; p < NP; p++) begin
      acc_l[p] += amp(cur_l[p]);
      acc_r[p] += amp(cur_r[p]);
    end
    fcnt++;
    @(negedge clk);
    chk("frame_pulse", 32'(frame_vld), 32'd0);
    if (fcnt == 4) begin
      chk("win_early", 32'(win_vld), 32'd0);
      exp_q.push_back({decide(acc_l[1], acc_r[1]), decide(acc_l[0], acc_r[0])});
      @(negedge clk);
      chk("win_latency", 32'(win_vld), 32'd1);
      e = exp_q.pop_front();
      chk("led_window", 32'(led), 32'(e));
      exp_led = e;
      for (int p = 0; p < NP; p++) begin
        acc_l[p] = 0;
        acc_r[p] = 0;
      end
      fcnt = 0;
      @(negedge clk);
      chk("win_pulse", 32'(win_vld), 32'd0);
    end
  endtask

  task automatic run_frames(input int n, input logic [23:0] l0, input logic [23:0] r0,
                            input logic [23:0] l1, input logic [23:0] r1);
    for (int f = 0; f < n; f++) begin
      set_cur(l0, r0, l1, r1);
      wait_frame();
    end
  endtask

  // First frame values must be in place before release, since slot 0 starts then.
  task automatic release_reset(input logic [23:0] l0, input logic [23:0] r0,
                               input logic [23:0] l1, input logic [23:0] r1);
    set_cur(l0, r0, l1, r1);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin : main
    logic pmc, pws;
    int lmc, lws, lfv;
    int mc_bad, ws_bad, fv_bad, mc_n, ws_n, fv_n;

    set_cur('0, '0, '0, '0);
    model_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_mic_clk", 32'(mic_clk), 32'd0);
    chk("rst_mic_ws", 32'(mic_ws), 32'd0);
    chk("rst_led", 32'(led), 32'hF);
    chk("rst_frame_vld", 32'(frame_vld), 32'd0);
    chk("rst_win_vld", 32'(win_vld), 32'd0);

    // Bit-clock and word-select timing
    rst = 1'b0;
    pmc = mic_clk; pws = mic_ws;
    lmc = -1; lws = -1; lfv = -1;
    mc_bad = 0; ws_bad = 0; fv_bad = 0; mc_n = 0; ws_n = 0; fv_n = 0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (mic_clk !== pmc) begin
        if (lmc >= 0 && (i - lmc) != 2) mc_bad++;
        lmc = i; mc_n++;
      end
      if (mic_ws !== pws) begin
        if (!(pmc === 1'b1 && mic_clk === 1'b0)) ws_bad++;
        if (lws >= 0 && (i - lws) != 128) ws_bad++;
        lws = i; ws_n++;
      end
      if (frame_vld === 1'b1) begin
        if (lfv >= 0 && (i - lfv) != 256) fv_bad++;
        lfv = i; fv_n++;
      end
      pmc = mic_clk; pws = mic_ws;
    end
    chk("mic_clk_period", 32'(mc_bad), 32'd0);
    chk("mic_clk_edges", 32'(mc_n >= 340), 32'd1);
    chk("ws_timing", 32'(ws_bad), 32'd0);
    chk("ws_edges", 32'(ws_n >= 4), 32'd1);
    chk("frame_period", 32'(fv_bad), 32'd0);
    chk("frame_count", 32'(fv_n >= 2), 32'd1);

    // Directed windows
    rst = 1'b1;
    repeat (2) @(negedge clk);
    release_reset(24'h100000, 24'h000000, 24'h000000, 24'h100000);
    wait_frame();
    run_frames(3, 24'h100000, 24'h000000, 24'h000000, 24'h100000);
    chk("dir_pairs", 32'(led), 32'b0110);

    run_frames(4, 24'hF00000, 24'h000000, 24'h800000, 24'h000000);
    chk("dir_negative", 32'(led), 32'b1010);

    run_frames(4, 24'h010000, 24'h00E000, 24'h010000, 24'h00F000);
    chk("dir_threshold", 32'(led), 32'b1110);

    run_frames(4, 24'h00E000, 24'h010000, 24'h000000, 24'h000000);
    chk("dir_swap", 32'(led), 32'b1101);

    // Reset in the middle of a window and a slot
    run_frames(2, 24'h400000, 24'h000000, 24'h400000, 24'h000000);
    repeat (50) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_mic_clk", 32'(mic_clk), 32'd0);
    chk("midrst_mic_ws", 32'(mic_ws), 32'd0);
    chk("midrst_led", 32'(led), 32'hF);
    chk("midrst_frame_vld", 32'(frame_vld), 32'd0);
    chk("midrst_win_vld", 32'(win_vld), 32'd0);
    repeat (3) @(negedge clk);
    release_reset(24'h010000, 24'h012000, 24'h012000, 24'h010000);
    wait_frame();
    run_frames(3, 24'h010000, 24'h012000, 24'h012000, 24'h010000);
    chk("postrst_led", 32'(led), 32'b1001);

    // Random windows against the model
    for (int w = 0; w < 6; w++) begin
      for (int f = 0; f < 4; f++) begin
        set_cur(rnd_val(), rnd_val(), rnd_val(), rnd_val());
        wait_frame();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
